// File: rtl/tron_fetch_pkg.sv
// -----------------------------------------------------------------------------
// tron_fetch_pkg
//   Types and helpers that the Tron fetch buffer, its prefetch FIFO and its bus
//   interface share.
//   Contents:
//     TRON_DATA_W  default bus / instruction / load-data width
//     word_t       one bus word of TRON_DATA_W bits
//     occ_e        prefetch queue occupancy class (EMPTY / PARTIAL / FULL)
//     clog2_depth  pointer width for a power-of-two queue depth
//     occ_of       maps an entry count onto its occupancy class
// -----------------------------------------------------------------------------
package tron_fetch_pkg;

   localparam int TRON_DATA_W = 16;

   typedef logic [TRON_DATA_W-1:0] word_t;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_e;

   // Number of bits needed to index 'depth' entries (depth is a power of two).
   function automatic int clog2_depth(input int depth);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < depth) w = i + 1;
      end
      return w;
   endfunction

   function automatic occ_e occ_of(input int cnt, input int depth);
      if (cnt == 0)          return OCC_EMPTY;
      else if (cnt >= depth) return OCC_FULL;
      else                   return OCC_PARTIAL;
   endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// -----------------------------------------------------------------------------
// fetch_buffer_if
//   Bus bundle between the memory data bus / decode stage and fetch_buffer.
//   master: the surrounding core (drives bus words, flush and decode ready)
//   slave : fetch_buffer (drives instruction queue head, load data, status)
//   Signals:
//     fetch_phase, data_valid, data_in  memory read bus and its phase
//     flush                             branch taken, drop queued instructions
//     instr, instr_valid, instr_ready   valid/ready head of the prefetch queue
//     mem_data, mem_data_valid          held load word and its one-cycle strobe
//     fetch_req                         queue has room for another read
//     count                             entries currently queued (0..DEPTH)
//     overflow                          sticky: an instruction word was dropped
// -----------------------------------------------------------------------------
interface fetch_buffer_if #(
   parameter int DATA_W = tron_fetch_pkg::TRON_DATA_W,
   parameter int DEPTH  = 4
);

   localparam int CNT_W = tron_fetch_pkg::clog2_depth(DEPTH) + 1;

   logic              fetch_phase;
   logic              data_valid;
   logic [DATA_W-1:0] data_in;
   logic              flush;
   logic [DATA_W-1:0] instr;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] mem_data;
   logic              mem_data_valid;
   logic              fetch_req;
   logic [CNT_W-1:0]  count;
   logic              overflow;

   modport master (
      output fetch_phase, data_valid, data_in, flush, instr_ready,
      input  instr, instr_valid, mem_data, mem_data_valid, fetch_req, count, overflow
   );

   modport slave (
      input  fetch_phase, data_valid, data_in, flush, instr_ready,
      output instr, instr_valid, mem_data, mem_data_valid, fetch_req, count, overflow
   );

endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO used as the instruction prefetch queue. Pointers wrap
//   modulo DEPTH (power of two); a synchronous flush empties the queue.
//   Ports:
//     clk, reset  rising-edge clock, asynchronous active-high reset
//     wrEn        write wrData (ignored while full unless rdEn pops this cycle)
//     rdEn        advance past the head entry (ignored while empty)
//     flush       empty the queue at the next edge; wrEn/rdEn are ignored
//     wrData      word to enqueue
//     rdData      head entry, 0 while empty
//     count       registered occupancy (0..DEPTH)
//     occ         registered occupancy class
// -----------------------------------------------------------------------------
module fetch_fifo import tron_fetch_pkg::*; #(
   parameter  int DATA_W = TRON_DATA_W,
   parameter  int DEPTH  = 4,
   localparam int PTR_W  = clog2_depth(DEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wrEn,
   input  logic              rdEn,
   input  logic              flush,
   input  logic [DATA_W-1:0] wrData,
   output logic [DATA_W-1:0] rdData,
   output logic [CNT_W-1:0]  count,
   output occ_e              occ
);

   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtr;
   logic [CNT_W-1:0]  nextCount;
   logic              wrAccept;
   logic              rdAccept;

   // A pop frees a slot in the same cycle, so push+pop is legal while full.
   assign rdAccept = rdEn & (occ != OCC_EMPTY) & ~flush;
   assign wrAccept = wrEn & ((occ != OCC_FULL) | rdAccept) & ~flush;

   // NOTE: every variable assigned in always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      nextCount = count;
      if (wrAccept && !rdAccept)      nextCount = count + CNT_ONE;
      else if (rdAccept && !wrAccept) nextCount = count - CNT_ONE;
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         occ   <= OCC_EMPTY;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         occ   <= OCC_EMPTY;
      end else begin
         if (wrAccept) wrPtr <= wrPtr + PTR_ONE;
         if (rdAccept) rdPtr <= rdPtr + PTR_ONE;
         count <= nextCount;
         occ   <= occ_of(int'(nextCount), DEPTH);
      end
   end

   // NOTE: the storage array has no reset; its contents are only observed
   // through rdData, which is forced to 0 while the queue is empty.
   always_ff @(posedge clk) begin
      if (wrAccept) mem[wrPtr] <= wrData;
   end

   assign rdData = (occ == OCC_EMPTY) ? '0 : mem[rdPtr];

endmodule

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   Sits between the memory data bus and the Tron decode stage. Fetch-phase bus
//   words are queued in a DEPTH-entry prefetch FIFO presented to decode as
//   valid/ready; load-phase words are captured in a held register with a
//   one-cycle valid strobe. A taken branch (flush) empties the queue.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bus    fetch_buffer_if.slave (bus words, flush, decode handshake, status)
// -----------------------------------------------------------------------------
module fetch_buffer import tron_fetch_pkg::*; #(
   parameter int DATA_W = TRON_DATA_W,
   parameter int DEPTH  = 4
) (
   input logic           clk,
   input logic           reset,
   fetch_buffer_if.slave bus
);

   localparam int CNT_W = clog2_depth(DEPTH) + 1;

   logic              push;
   logic              pop;
   logic              load;
   logic              full;
   logic              empty;
   occ_e              occ;
   logic [DATA_W-1:0] headWord;
   logic [CNT_W-1:0]  fifoCount;
   logic              overflowQ;
   logic [DATA_W-1:0] memDataQ;
   logic              memDataValidQ;

   // A fetch word arriving with flush belongs to the abandoned path.
   assign push = bus.data_valid & bus.fetch_phase & ~bus.flush;
   assign pop  = bus.instr_valid & bus.instr_ready & ~bus.flush;
   assign load = bus.data_valid & ~bus.fetch_phase;

   assign full  = (occ == OCC_FULL);
   assign empty = (occ == OCC_EMPTY);

   fetch_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .wrEn   (push),
      .rdEn   (pop),
      .flush  (bus.flush),
      .wrData (bus.data_in),
      .rdData (headWord),
      .count  (fifoCount),
      .occ    (occ)
   );

   // Sticky until reset: a fetch word was lost because the queue was full.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflowQ <= 1'b0;
      end else if (push && full && !pop) begin
         overflowQ <= 1'b1;
      end
   end

   // Load path: independent of flush and of queue state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         memDataQ      <= '0;
         memDataValidQ <= 1'b0;
      end else begin
         memDataValidQ <= load;
         if (load) memDataQ <= bus.data_in;
      end
   end

   assign bus.instr          = headWord;
   assign bus.instr_valid    = ~empty;
   assign bus.count          = fifoCount;
   assign bus.overflow       = overflowQ;
   assign bus.mem_data       = memDataQ;
   assign bus.mem_data_valid = memDataValidQ;
   // Held low during reset so every output reads 0 while reset is asserted.
   assign bus.fetch_req      = ~full & ~bus.flush & ~reset;

endmodule

// File: tb/tb_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_buffer
//   Self-checking bench for fetch_buffer (DATA_W=16, DEPTH=4). A queue-based
//   reference model tracks queued instructions, the overflow flag and the load
//   register; directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_fetch_buffer;
   import tron_fetch_pkg::*;

   localparam int DEPTH = 4;
   localparam int DW    = TRON_DATA_W;

   logic clk = 1'b0;
   logic reset;

   fetch_buffer_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus();

   fetch_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model state
   word_t modelQ[$];
   bit    modelOvf;
   word_t modelMem;
   bit    modelMemValid;

   int nChecks = 0;
   int nPassed = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      if (observed === expected) nPassed++;
      else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   task automatic resetModel();
      modelQ.delete();
      modelOvf      = 1'b0;
      modelMem      = '0;
      modelMemValid = 1'b0;
   endtask

   task automatic checkOutputs(input string tag);
      check({tag, ".instr"},       32'(bus.instr),          (modelQ.size() != 0) ? 32'(modelQ[0]) : 32'd0);
      check({tag, ".instr_valid"}, 32'(bus.instr_valid),    32'(modelQ.size() != 0));
      check({tag, ".count"},       32'(bus.count),          32'(modelQ.size()));
      check({tag, ".fetch_req"},   32'(bus.fetch_req),      32'((modelQ.size() != DEPTH) && !bus.flush));
      check({tag, ".overflow"},    32'(bus.overflow),       32'(modelOvf));
      check({tag, ".mem_data"},    32'(bus.mem_data),       32'(modelMem));
      check({tag, ".mem_valid"},   32'(bus.mem_data_valid), 32'(modelMemValid));
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, ".instr"},       32'(bus.instr),          32'd0);
      check({tag, ".instr_valid"}, 32'(bus.instr_valid),    32'd0);
      check({tag, ".count"},       32'(bus.count),          32'd0);
      check({tag, ".fetch_req"},   32'(bus.fetch_req),      32'd0);
      check({tag, ".overflow"},    32'(bus.overflow),       32'd0);
      check({tag, ".mem_data"},    32'(bus.mem_data),       32'd0);
      check({tag, ".mem_valid"},   32'(bus.mem_data_valid), 32'd0);
   endtask

   // Apply one cycle of inputs (called at a falling edge), advance the model by
   // the queue rules, then compare all outputs at the next falling edge.
   task automatic cycle(input string tag, input bit fp, input bit dv, input word_t d,
                        input bit fl, input bit rdy);
      bit doPush, doPop, doLoad;
      bus.fetch_phase = fp;
      bus.data_valid  = dv;
      bus.data_in     = d;
      bus.flush       = fl;
      bus.instr_ready = rdy;

      doPush = dv && fp && !fl;
      doPop  = (modelQ.size() != 0) && rdy && !fl;
      doLoad = dv && !fp;

      if (fl) begin
         modelQ.delete();
      end else begin
         if (doPop) void'(modelQ.pop_front());
         if (doPush) begin
            if (modelQ.size() < DEPTH) modelQ.push_back(d);
            else                       modelOvf = 1'b1;
         end
      end
      modelMemValid = doLoad;
      if (doLoad) modelMem = d;

      @(posedge clk);
      @(negedge clk);
      checkOutputs(tag);
   endtask

   task automatic pushWord(input string tag, input word_t d, input bit rdy);
      cycle(tag, 1'b1, 1'b1, d, 1'b0, rdy);
   endtask

   task automatic idle(input string tag, input bit rdy);
      cycle(tag, 1'b1, 1'b0, word_t'(16'h0), 1'b0, rdy);
   endtask

   initial begin
      word_t drainSeq[4];
      word_t lastSeen;

      reset           = 1'b1;
      bus.fetch_phase = 1'b0;
      bus.data_valid  = 1'b0;
      bus.data_in     = '0;
      bus.flush       = 1'b0;
      bus.instr_ready = 1'b0;
      resetModel();

      #3;
      checkAllZero("por");
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutputs("por_release");

      // 1: asynchronous reset in the middle of a run with three entries queued
      pushWord("t1_fill", 16'hA001, 1'b0);
      pushWord("t1_fill", 16'hA002, 1'b0);
      pushWord("t1_fill", 16'hA003, 1'b0);
      check("t1.count3", 32'(bus.count), 32'd3);
      bus.data_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      resetModel();
      checkAllZero("t1_async");
      @(negedge clk);
      checkAllZero("t1_held");
      reset = 1'b0;
      #1;
      checkOutputs("t1_release");
      pushWord("t1_first_push", 16'hB001, 1'b0);
      check("t1.first_push_count", 32'(bus.count), 32'd1);
      idle("t1_drain", 1'b1);

      // 2: fill to DEPTH with decode stalled, then drain in order
      pushWord("t2_fill", 16'h1111, 1'b0);
      pushWord("t2_fill", 16'h2222, 1'b0);
      pushWord("t2_fill", 16'h3333, 1'b0);
      pushWord("t2_fill", 16'h4444, 1'b0);
      check("t2.full_count", 32'(bus.count), 32'd4);
      check("t2.full_fetch_req", 32'(bus.fetch_req), 32'd0);
      idle("t2_stall", 1'b0);
      drainSeq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      for (int i = 0; i < 4; i++) begin
         check("t2.drain_order", 32'(bus.instr), 32'(drainSeq[i]));
         idle("t2_drain", 1'b1);
      end
      check("t2.empty_valid", 32'(bus.instr_valid), 32'd0);

      // 3: push+pop while full keeps count; push while full without pop drops
      pushWord("t3_fill", 16'h1111, 1'b0);
      pushWord("t3_fill", 16'h2222, 1'b0);
      pushWord("t3_fill", 16'h3333, 1'b0);
      pushWord("t3_fill", 16'h4444, 1'b0);
      pushWord("t3_push_pop", 16'h5555, 1'b1);
      check("t3.pp_count", 32'(bus.count), 32'd4);
      check("t3.pp_overflow", 32'(bus.overflow), 32'd0);
      pushWord("t3_drop", 16'h6666, 1'b0);
      check("t3.drop_count", 32'(bus.count), 32'd4);
      check("t3.overflow_set", 32'(bus.overflow), 32'd1);
      drainSeq = '{16'h2222, 16'h3333, 16'h4444, 16'h5555};
      for (int i = 0; i < 4; i++) begin
         check("t3.drain_order", 32'(bus.instr), 32'(drainSeq[i]));
         idle("t3_drain", 1'b1);
      end
      check("t3.overflow_sticky", 32'(bus.overflow), 32'd1);

      // 4: flush with a coincident push; the pushed word must never surface
      pushWord("t4_fill", 16'h0A01, 1'b0);
      pushWord("t4_fill", 16'h0A02, 1'b0);
      pushWord("t4_fill", 16'h0A03, 1'b0);
      cycle("t4_flush", 1'b1, 1'b1, 16'h7777, 1'b1, 1'b1);
      check("t4.count", 32'(bus.count), 32'd0);
      check("t4.instr_valid", 32'(bus.instr_valid), 32'd0);
      idle("t4_after", 1'b1);
      check("t4.no_stale", 32'(bus.instr_valid), 32'd0);

      // 5: load capture, strobe, hold; back-to-back loads; load during flush
      pushWord("t5_fill", 16'h0C01, 1'b0);
      pushWord("t5_fill", 16'h0C02, 1'b0);
      cycle("t5_load", 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
      check("t5.mem_data", 32'(bus.mem_data), 32'h0000BEEF);
      check("t5.mem_valid", 32'(bus.mem_data_valid), 32'd1);
      check("t5.queue_kept", 32'(bus.count), 32'd2);
      idle("t5_hold", 1'b0);
      check("t5.strobe_once", 32'(bus.mem_data_valid), 32'd0);
      check("t5.mem_held", 32'(bus.mem_data), 32'h0000BEEF);
      cycle("t5_b2b", 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1);
      cycle("t5_b2b", 1'b0, 1'b1, 16'h5678, 1'b0, 1'b1);
      check("t5.b2b_valid", 32'(bus.mem_data_valid), 32'd1);
      check("t5.b2b_data", 32'(bus.mem_data), 32'h00005678);
      cycle("t5_load_flush", 1'b0, 1'b1, 16'h9ABC, 1'b1, 1'b0);
      check("t5.load_in_flush", 32'(bus.mem_data), 32'h00009ABC);
      idle("t5_end", 1'b1);

      // 6: pointer wrap with occupancy bouncing between 1 and 2
      pushWord("t6_first", 16'hE000, 1'b0);
      for (int i = 1; i < 10; i++) begin
         lastSeen = bus.instr;
         pushWord("t6_push", word_t'(16'hE000 + i), 1'b0);
         check("t6.hold_head", 32'(bus.instr), 32'(lastSeen));
         idle("t6_pop", 1'b1);
         check("t6.order", 32'(bus.instr), 32'(16'hE000 + i));
      end
      idle("t6_drain", 1'b1);

      // Randomized traffic: decode mostly stalled at first so the queue fills
      for (int n = 0; n < 600; n++) begin
         bit fp, dv, fl, rdy;
         fp  = ($urandom_range(0, 3) != 0);
         dv  = ($urandom_range(0, 9) < 7);
         fl  = ($urandom_range(0, 19) == 0);
         rdy = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
         cycle("rand", fp, dv, word_t'($urandom_range(0, 16'hFFFF)), fl, rdy);
      end

      $display("%0d/%0d checks passed", nPassed, nChecks);
      $finish;
   end

endmodule
